// File: rtl/cdc_channel_arbiter.sv
// Round-robin arbiter feeding the source side of a toggle CDC channel.
// Holds one word at a time, with a stall watchdog and transfer counters.
module cdc_channel_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             cfg_enable,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_data,
  output logic                           cdc_valid,
  input  logic                           cdc_ready,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [CNT_WIDTH-1:0]           xfer_count,
  output logic [CNT_WIDTH-1:0]           drop_count
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_ISSUE = 1'b1;
  localparam int   WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic                           r_state;
  logic [ID_WIDTH-1:0]            r_ptr;
  logic [ID_WIDTH+DATA_WIDTH-1:0] r_hold;
  logic                           r_valid;
  logic [WD_W-1:0]                r_wd;
  logic                           r_terr;
  logic [CNT_WIDTH-1:0]           r_xfer;
  logic [CNT_WIDTH-1:0]           r_drop;

  logic [NUM_REQ-1:0]   w_elig;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [ID_WIDTH-1:0]  w_off;
  logic [ID_WIDTH:0]    w_sum;
  logic [ID_WIDTH-1:0]  w_gnt;
  logic [ID_WIDTH-1:0]  w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_payload;
  logic                 w_hs;
  logic                 w_accept;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    w_elig  = req_valid & cfg_enable;
    w_dbl   = {w_elig, w_elig} >> r_ptr;
    w_rot   = w_dbl[NUM_REQ-1:0];
    w_found = |w_rot;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k[ID_WIDTH-1:0];
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_WIDTH+1)'(NUM_REQ))
      w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
    w_gnt = w_sum[ID_WIDTH-1:0];
    if (w_gnt == ID_WIDTH'(NUM_REQ - 1))
      w_ptr_nxt = '0;
    else
      w_ptr_nxt = w_gnt + ID_WIDTH'(1);
    w_payload = req_data[w_gnt*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_hs      = r_valid && cdc_ready;
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_terr  <= 1'b0;
      r_xfer  <= '0;
      r_drop  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_hold  <= {w_gnt, w_payload};
            r_ptr   <= w_ptr_nxt;
            r_wd    <= '0;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A handshake on the watchdog's last cycle still wins.
          if (w_hs) begin
            r_xfer  <= r_xfer + CNT_WIDTH'(1);
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wd == WD_MAX) begin
            r_terr  <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + CNT_WIDTH'(1);
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cdc_data    = r_hold;
  assign cdc_valid   = r_valid;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_terr;
  assign xfer_count  = r_xfer;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Directed bench for cdc_channel_arbiter: grants, masking, timeout,
// counter wrap/saturation and reset during a held word.
module tb_cdc_channel_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int IW  = 2;
  localparam int TO  = 8;
  localparam int CW  = 4;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    cfg_enable;
  logic [IW+DW-1:0] cdc_data;
  logic             cdc_valid;
  logic             cdc_ready;
  logic             busy;
  logic             timeout_err;
  logic [CW-1:0]    xfer_count;
  logic [CW-1:0]    drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  exp_id [32];
  logic [31:0] lane_data [NR];

  cdc_channel_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cfg_enable(cfg_enable),
    .cdc_data(cdc_data), .cdc_valid(cdc_valid),
    .cdc_ready(cdc_ready), .busy(busy),
    .timeout_err(timeout_err),
    .xfer_count(xfer_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    cdc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_grants(input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < 4*n + 8 && seen < n; c++) begin
      @(negedge clk);
      if (cdc_valid) begin
        chk($sformatf("g%0d_id", seen), 64'(cdc_data[33:32]),
            64'(exp_id[seen]));
        chk($sformatf("g%0d_pl", seen), 64'(cdc_data[31:0]),
            64'(lane_data[exp_id[seen]]));
        seen++;
        if (seen == n) req_valid = '0;
      end
    end
    chk("grant_cnt", 64'(seen), 64'(n));
    @(negedge clk);
  endtask

  task automatic do_timeout(input bit ready_at_end, output int cnt);
    req_valid = 4'b0001;
    cdc_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = '0;
      if (cdc_valid) begin
        cnt++;
        if (ready_at_end && cnt == TO) cdc_ready = 1'b1;
      end
    end
    cdc_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < NR; i++) lane_data[i] = 32'hA5A5_0000 | i;
    lane_data[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane_data[i];
    cfg_enable = '1;

    // reset state
    do_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(cdc_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_xfer",  64'(xfer_count), 64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    chk("rst_terr",  64'(timeout_err), 64'd0);
    chk("rst_data",  64'(cdc_data),   64'd0);

    // single request, requester 2
    req_valid = 4'b0100;
    cdc_ready = 1'b1;
    #1;
    chk("s_ready", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("s_valid", 64'(cdc_valid), 64'd1);
    chk("s_data",  64'(cdc_data), {30'd0, 2'd2, 32'hDEAD_BEEF});
    chk("s_busy",  64'(busy), 64'd1);
    @(negedge clk);
    chk("s_xfer",  64'(xfer_count), 64'd1);
    chk("s_idle",  64'(cdc_valid), 64'd0);

    // fairness: all valid
    do_reset();
    @(negedge clk);
    for (int g = 0; g < 8; g++) exp_id[g] = 2'(g % 4);
    req_valid = '1;
    cdc_ready = 1'b1;
    run_grants(8);
    chk("rr_xfer", 64'(xfer_count), 64'd8);

    // enable mask 1010
    cfg_enable = 4'b1010;
    for (int g = 0; g < 4; g++) exp_id[g] = (g % 2 == 0) ? 2'd1 : 2'd3;
    req_valid = '1;
    run_grants(4);
    chk("mask_xfer", 64'(xfer_count), 64'd12);
    cfg_enable = '1;

    // timeout, then normal transfer, then handshake on limit cycle
    do_reset();
    @(negedge clk);
    do_timeout(1'b0, cnt);
    chk("to_cycles", 64'(cnt), 64'(TO));
    chk("to_terr",   64'(timeout_err), 64'd1);
    chk("to_drop",   64'(drop_count), 64'd1);
    chk("to_xfer",   64'(xfer_count), 64'd0);
    req_valid = 4'b0001;
    cdc_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    chk("post_valid", 64'(cdc_valid), 64'd1);
    @(negedge clk);
    cdc_ready = 1'b0;
    chk("post_xfer", 64'(xfer_count), 64'd1);
    chk("post_terr", 64'(timeout_err), 64'd1);
    do_timeout(1'b1, cnt);
    chk("edge_cycles", 64'(cnt), 64'(TO));
    chk("edge_xfer",   64'(xfer_count), 64'd2);
    chk("edge_drop",   64'(drop_count), 64'd1);

    // drop counter saturates
    for (int k = 0; k < 15; k++) do_timeout(1'b0, cnt);
    chk("sat_drop", 64'(drop_count), 64'd15);
    chk("sat_terr", 64'(timeout_err), 64'd1);

    // xfer counter wraps: 17 transfers into 4 bits
    do_reset();
    @(negedge clk);
    for (int g = 0; g < 17; g++) exp_id[g] = 2'd0;
    req_valid = 4'b0001;
    cdc_ready = 1'b1;
    run_grants(17);
    chk("wrap_xfer", 64'(xfer_count), 64'd1);

    // reset while holding a word
    cdc_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    chk("mr_valid", 64'(cdc_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_valid0", 64'(cdc_valid), 64'd0);
    chk("mr_busy",   64'(busy), 64'd0);
    chk("mr_xfer",   64'(xfer_count), 64'd0);
    repeat (TO + 4) @(negedge clk);
    chk("mr_drop",   64'(drop_count), 64'd0);
    chk("mr_terr",   64'(timeout_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_channel_arbiter.md
Name: cdc_channel_arbiter

Overview:
- Shares the source side of one toggle-based clock-domain-crossing channel between NUM_REQ requesters, all in the source clock domain.
- Round-robin arbitrates the requests, holds the winning word, and presents it with its requester ID to the channel's valid/ready source port.
- Detects a stalled channel with a watchdog, drops the held word, and reports the error.
- Keeps per-requester enable masking and a count of completed transfers.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per requester.
- ID_WIDTH, 2, width of the requester ID field; must satisfy 2**ID_WIDTH >= NUM_REQ.
- TIMEOUT_CYCLES, 1024, maximum cycles the arbiter may hold cdc_valid high without a handshake; must be at least 2.
- CNT_WIDTH, 16, width of the transfer and drop counters.

Ports:
- clk  in  1  single clock; same as the channel's source clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept strobe.
- cfg_enable  in  NUM_REQ  requester enable mask; a 0 bit excludes that requester from arbitration.
- cdc_data  out  ID_WIDTH+DATA_WIDTH  word to the channel as {id, payload}.
- cdc_valid  out  1  word valid to the channel.
- cdc_ready  in  1  channel ready.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky flag; set when a held word is dropped on timeout.
- xfer_count  out  CNT_WIDTH  number of completed cdc handshakes; wraps at full scale.
- drop_count  out  CNT_WIDTH  number of words dropped on timeout; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; round-robin pointer=0; holding register=0.
  - cdc_valid=0, cdc_data=0, req_ready=0, busy=0, timeout_err=0, xfer_count=0, drop_count=0, watchdog=0.
  - Reset mid-transfer discards the held word without counting it.
- Eligible set: req_valid & cfg_enable.
- Grant: search the eligible set from the pointer index upward, wrapping modulo NUM_REQ; the first eligible index wins.
- req_ready is combinational: one-hot, asserted only in IDLE on the grant index; all zero when the eligible set is empty.
- States:
  - IDLE:
    - If any requester is eligible, the transfer is accepted in this cycle (req_valid & req_ready).
    - Latch {grant index, payload} into the holding register.
    - Pointer becomes (grant+1) mod NUM_REQ.
    - Watchdog clears; next state is ISSUE.
  - ISSUE:
    - cdc_valid=1; cdc_data shows the holding register and stays stable.
    - If cdc_valid & cdc_ready: xfer_count increments, next state is IDLE.
    - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 without a handshake:
      - set timeout_err;
      - increment drop_count (saturating);
      - next state is IDLE.
    - A handshake in the same cycle as the watchdog limit counts as a transfer, not a drop.
  - There is no other state.
- cdc_valid is registered and never deasserts before a handshake, except on timeout.
- cdc_data holds its last value in IDLE.
- Latency:
  - Request accepted at cycle T; cdc_valid high at T+1.
  - If cdc_ready is already high, the handshake completes at T+1, IDLE is reached at T+2, and the next grant can occur at T+2.
  - Maximum throughput is one word per 2 cycles.
- Fairness: with all NUM_REQ requesters continuously eligible, each is granted exactly once in every NUM_REQ consecutive grants.
- cfg_enable changes take effect on the next IDLE grant. Clearing the enable bit of the requester whose word is held does not cancel that word.
- timeout_err clears only on reset.
- xfer_count wraps from all-ones to 0.

Test Plan:
- Reset, then 3 idle cycles → cdc_valid=0, req_ready=0, busy=0, both counters 0, timeout_err=0.
- Only requester 2 valid, data 0xDEADBEEF, cdc_ready=1 → req_ready=4'b0100 at T; cdc_valid=1 with cdc_data={2'd2,32'hDEADBEEF} at T+1; xfer_count=1 at T+2.
- All four requesters valid continuously, cdc_ready=1, 8 grants → grant order 0,1,2,3,0,1,2,3; xfer_count=8.
- cfg_enable=4'b1010, all requesters valid → only IDs 1 and 3 appear on cdc_data, alternating.
- TIMEOUT_CYCLES=8, one request, cdc_ready held 0 → cdc_valid is high for exactly 8 cycles then drops; timeout_err=1, drop_count=1, xfer_count=0; a following request with cdc_ready=1 completes normally and timeout_err stays 1.
- Reset asserted while in ISSUE with cdc_ready=0 → the next cycle shows cdc_valid=0 and state IDLE, and the dropped word is not counted in either counter.
